// File: rtl/multichannel_wavegen_pkg.sv
// Shared types and constants for the multichannel DDS generator.
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        CFG_AMP  = 2'd0,
        CFG_PADD = 2'd1,
        CFG_POFF = 2'd2,
        CFG_MODE = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SQUARE_PEAK = 2047;
    localparam logic [31:0] Q15_CLAMP = 32'h4000_0000;

    // Q15 product scaling; -1.0 * -1.0 would wrap, so it is clamped.
    function automatic logic signed [15:0] q15_term(
        input logic signed [31:0] prod
    );
        if (prod == Q15_CLAMP) return 16'sh7fff;
        return prod[30:15];
    endfunction

endpackage

// File: rtl/multichannel_wavegen_if.sv
// Config write bus and mixed sample output of the DDS generator.
interface multichannel_wavegen_if #(
    parameter int NCH   = 4,
    parameter int OUT_W = 16
);
    localparam int CW = $clog2(NCH);

    logic                    cfg_we;
    logic [CW-1:0]           cfg_ch;
    logic [1:0]              cfg_sel;
    logic [15:0]             cfg_data;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;

    modport master (
        output cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  sample_out, sample_valid
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_sel, cfg_data,
        output sample_out, sample_valid
    );
endinterface

// File: rtl/multichannel_wavegen_wave_select.sv
// Phase-to-waveform mapping for one channel slot, plus the sine lookup.
module sinetable (
    input  logic [13:0]        phase,
    output logic signed [11:0] w
);
    logic [13:0] hc;
    logic [24:0] t;
    logic [35:0] y;
    logic [11:0] mag;

    // Parabolic half-wave 4h(1-h), scaled to a 2047 peak.
    always_comb begin
        hc  = 14'd8192 - {1'b0, phase[12:0]};
        t   = 25'({14'd0, phase[12:0]} * {13'd0, hc});
        y   = {11'd0, t} * 36'd2047;
        mag = 12'(y >> 24);
        w   = phase[13] ? -$signed(mag) : $signed(mag);
    end
endmodule

module wave_select
    import wavegen_pkg::*;
(
    input  logic [13:0]        phase,
    input  mode_e              mode,
    output logic signed [11:0] w
);
    localparam logic signed [11:0] PEAK = 12'(SQUARE_PEAK);

    logic signed [11:0] sine_w;
    logic [10:0]        u;

    sinetable u_sine (
        .phase (phase),
        .w     (sine_w)
    );

    always_comb begin
        u = phase[13] ? ~phase[12:2] : phase[12:2];
        w = sine_w;
        unique case (mode)
            MODE_SINE:   w = sine_w;
            MODE_SQUARE: w = phase[13] ? -PEAK : PEAK;
            MODE_SAW:    w = {~phase[13], phase[12:2]};
            MODE_TRI:    w = {~u[10], u[9:0], 1'b0};
        endcase
    end
endmodule

// File: rtl/multichannel_wavegen.sv
// Time-multiplexed N-channel DDS generator: one channel slot per cycle,
// terms summed and saturated into one mixed sample per frame.
module multichannel_wavegen
    import wavegen_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic                  phase_sync,
    multichannel_wavegen_if.slave bus,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = $clog2(NCH);
    localparam int SW = OUT_W + CW;

    localparam logic signed [SW-1:0] SMAX =
        {{(CW+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN =
        {{(CW+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] SAT_HI =
        {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_LO =
        {1'b1, {(OUT_W-1){1'b0}}};

    state_e state_q, state_d;

    logic [CW-1:0]           slot_q, slot_d;
    logic signed [SW-1:0]    sum_q, sum_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    logic [PHASE_W-1:0] acc_q  [NCH];
    logic [PHASE_W-1:0] acc_d  [NCH];
    logic signed [15:0] amp_q  [NCH];
    logic signed [15:0] amp_d  [NCH];
    logic [15:0]        padd_q [NCH];
    logic [15:0]        padd_d [NCH];
    logic [15:0]        poff_q [NCH];
    logic [15:0]        poff_d [NCH];
    mode_e              mode_q [NCH];
    mode_e              mode_d [NCH];

    logic [13:0]        phase_sel;
    logic signed [11:0] wave_w;
    logic signed [15:0] s;
    logic signed [15:0] amp_sel;
    logic signed [31:0] prod;
    logic signed [15:0] term;

    // Offset lands in the top 16 bits of the accumulator.
    function automatic logic [PHASE_W-1:0] place_off(
        input logic [15:0] off
    );
        logic [PHASE_W+15:0] t;
        t = {off, {PHASE_W{1'b0}}};
        return PHASE_W'(t >> 16);
    endfunction

    assign phase_sel = acc_q[slot_q][PHASE_W-1 -: 14];
    assign amp_sel   = amp_q[slot_q];
    assign s         = {wave_w, 4'b0000};
    assign prod      = 32'(amp_sel) * 32'(s);
    assign term      = q15_term(prod);

    wave_select u_wave (
        .phase (phase_sel),
        .mode  (mode_q[slot_q]),
        .w     (wave_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (sample_tick && !phase_sync) state_d = RUN;
            RUN: begin
                if (phase_sync)                    state_d = IDLE;
                else if (slot_q == CW'(NCH - 1))   state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_d  = slot_q;
        sum_d   = sum_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = sample_tick & ~phase_sync & (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    slot_d = '0;
                    sum_d  = '0;
                end
            end
            RUN: begin
                sum_d  = sum_q + SW'(term);
                slot_d = slot_q + CW'(1);
            end
            DONE: begin
                if (!phase_sync) begin
                    valid_d = 1'b1;
                    if (sum_q > SMAX)      out_d = SAT_HI;
                    else if (sum_q < SMIN) out_d = SAT_LO;
                    else                   out_d = OUT_W'(sum_q);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        amp_d  = amp_q;
        padd_d = padd_q;
        poff_d = poff_q;
        mode_d = mode_q;
        if (state_q == RUN)
            acc_d[slot_q] = acc_q[slot_q] + PHASE_W'(padd_q[slot_q]);
        if (phase_sync)
            for (int i = 0; i < NCH; i++) acc_d[i] = place_off(poff_q[i]);
        if (bus.cfg_we && (int'(bus.cfg_ch) < NCH)) begin
            unique case (cfg_sel_e'(bus.cfg_sel))
                CFG_AMP:  amp_d[bus.cfg_ch]  = bus.cfg_data;
                CFG_PADD: padd_d[bus.cfg_ch] = bus.cfg_data;
                CFG_POFF: poff_d[bus.cfg_ch] = bus.cfg_data;
                CFG_MODE: mode_d[bus.cfg_ch] = mode_e'(bus.cfg_data[1:0]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                amp_q[i]  <= '0;
                padd_q[i] <= '0;
                poff_q[i] <= '0;
                mode_q[i] <= MODE_SINE;
            end
        end else begin
            slot_q  <= slot_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            acc_q   <= acc_d;
            amp_q   <= amp_d;
            padd_q  <= padd_d;
            poff_q  <= poff_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign busy             = (state_q != IDLE);
    assign overrun          = ovr_q;

endmodule

// File: doc/multichannel_wavegen.md
Name: multichannel_wavegen

Overview:
- Time-multiplexed N-channel DDS (direct digital synthesis) waveform generator; successor to the single-channel sine computer.
- Per channel: phase accumulator, phase increment, phase offset, signed amplitude and waveform mode (sine/square/saw/triangle).
- One shared sine lookup and one multiplier serve all channels, one channel per cycle per frame. Channel terms are summed and saturated into one mixed sample per sample_tick.
- Sits between the control/config logic and the audio/DAC output stage.

Parameters:
NCH, 4, number of channels (power of 2, 2..16)
PHASE_W, 16, phase accumulator width (>=14)
OUT_W, 16, signed output sample width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_tick  in  1  start one frame (one output sample)
phase_sync  in  1  reload every accumulator with its phase offset
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NCH)  target channel
cfg_sel  in  2  0 amp, 1 phaseadd, 2 phaseoffset, 3 mode (cfg_data[1:0])
cfg_data  in  16  write data
sample_out  out  OUT_W  signed mixed sample
sample_valid  out  1  one-cycle strobe, sample_out updated
busy  out  1  frame in progress
overrun  out  1  one-cycle pulse: sample_tick dropped while busy

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low.
- Reset values: all outputs 0; all per-channel registers 0; accumulators 0; FSM in IDLE.
- FSM states and transitions:
  - IDLE: on sample_tick, go to RUN with slot=0 and sum=0.
  - RUN: one channel per cycle, slot 0..NCH-1. After slot NCH-1, go to DONE.
  - DONE: register the saturated sum into sample_out, pulse sample_valid, return to IDLE.
- Latency: sample_tick sampled high at edge T gives sample_valid high in the cycle after edge T+NCH+1. busy is high from T+1 until DONE ends.
- Slot i operations, all in the same cycle:
  - Waveform w (12-bit signed) is taken from acc[i] top 14 bits, p = acc[i][PHASE_W-1 -: 14], per mode:
    - Mode 0 (sine): sinetable(p).
    - Mode 1 (square): +2047 if acc MSB is 0, else -2047.
    - Mode 2 (saw): {~acc MSB, next 11 bits}; phase 0 gives -2048.
    - Mode 3 (triangle): u = MSB ? ~bits[MSB-1 -: 11] : bits[MSB-1 -: 11]; w = {u,0} - 2048.
  - s = w <<< 4 (16-bit signed); prod = amp[i] * s (32-bit signed).
  - term = prod[30:15]. If prod == 32'h40000000 (amp 0x8000 × s 0x8000), term = 0x7FFF.
  - sum += sign-extended term; sum width OUT_W + $clog2(NCH).
  - acc[i] <= acc[i] + phaseadd[i], modulo 2^PHASE_W. phaseadd is zero-extended to PHASE_W; offset occupies the top 16 bits.
- Saturation in DONE: sum > 2^(OUT_W-1)-1 gives 0x7FFF; sum < -2^(OUT_W-1) gives 0x8000.
- Accumulators advance only in their slot, i.e. once per frame.
- sample_tick while busy (including DONE): ignored, overrun pulses, frame unaffected.
- phase_sync:
  - All acc[i] <= offset[i] on the next edge.
  - If busy, the frame aborts: FSM goes to IDLE, no sample_valid, sample_out holds.
  - phase_sync wins over a simultaneous sample_tick (tick dropped, no overrun).
- Config writes:
  - Take effect at the next edge.
  - A write to channel i on the same edge as slot i is not seen by that slot.
  - cfg_ch >= NCH is ignored.
  - Offset writes do not touch acc until phase_sync or reset.
- reset_n low mid-frame: immediate return to reset values.

Decomposition:
- Shared package wavegen_pkg:
  - mode encodings MODE_SINE/SQUARE/SAW/TRI;
  - cfg_sel encodings CFG_AMP/CFG_PADD/CFG_POFF/CFG_MODE;
  - FSM state enum IDLE/RUN/DONE;
  - SQUARE_PEAK = 2047;
  - Q15 clamp constant 32'h40000000.
- Sub-module wave_select: combinational; inputs phase(14) and mode(2), output 12-bit signed w; instantiates the existing sinetable.

Test Plan:
- Frame timing and saturated sum:
  - Setup: NCH=4, ch0 amp 0x7FFF, mode square, others amp 0.
  - Stimulus: sample_tick.
  - Expected: sample_valid 6 cycles later (T+NCH+1 = T+5, seen in the following cycle); sample_out 0x7FEF (32751).
- Sum saturation: ch0 and ch1 both amp 0x7FFF square -> sum 65502, sample_out 0x7FFF.
- Q15 clamp: ch0 amp 0x8000, mode saw, phase 0 (w = -2048, prod 0x40000000) -> sample_out 0x7FFF.
- Phase advance: ch0 amp 0x4000, square, phaseadd 0x4000; four ticks -> 0x3FF8, 0x3FF8, 0xC008, 0xC008; fifth tick -> 0x3FF8 (wrap).
- Offset and abort:
  - Part 1: ch0 offset 0x8000, square, amp 0x4000; phase_sync, then tick -> 0xC008.
  - Part 2: phase_sync asserted mid-frame -> no sample_valid, busy drops next cycle.
- Overrun and reset:
  - Part 1: second sample_tick 2 cycles after the first -> overrun pulses once, exactly one sample_valid.
  - Part 2: reset_n low mid-frame -> busy, sample_out, sample_valid all 0 immediately.
